// File: rtl/fptd_seq_pkg.sv
// Shared types and helpers for the FPTD dual-core run sequencer.
//   seq_state_t : sequencer FSM states
//   core_res_t  : one core's captured result (valid flag + error count)
//   sat_add     : saturating adder used by the mismatch counter and error sums
package fptd_seq_pkg;

  localparam int EW_DEF   = 7;    // core Errors width
  localparam int RW_DEF   = 8;    // run counter / NumRuns / MismatchCnt width
  localparam int SW_DEF   = 16;   // accumulated error sum width
  localparam int TW_DEF   = 8;    // watchdog counter width
  localparam int TMAX_DEF = 255;  // watchdog limit in cycles

  // Captured errors are held at a fixed maximum width; narrower cores are
  // zero-extended into it, which leaves equality and addition unchanged.
  localparam int EW_MAX = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_LOAD,
    S_START,
    S_WAIT_RDY,
    S_COMPARE,
    S_NEXT,
    S_DONE
  } seq_state_t;

  typedef struct packed {
    logic              valid;
    logic [EW_MAX-1:0] errors;
  } core_res_t;

  // a + b clamped to max_val; the 33-bit sum cannot wrap.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

endpackage

// File: rtl/fptd_seq_wdog.sv
// Watchdog for the WAIT_RDY phase.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : synchronous clear (issued while the sequencer is in START)
//   i_en           : count this cycle (sequencer in WAIT_RDY)
//   o_expire       : this cycle's increment brings the count to TMAX
module fptd_seq_wdog #(
  parameter int TW   = 8,
  parameter int TMAX = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [TW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its peers, independent of block order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != TW'(TMAX))) begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  // Flagged one cycle early so the sequencer leaves WAIT_RDY on the very
  // edge at which the count reaches TMAX.
  assign o_expire = i_en && (r_cnt == TW'(TMAX - 1));

endmodule

// File: rtl/fptd_run_seq.sv
// Run sequencer for the dual-core FPTD error-rate test.
// Per run: wait for a fresh input vector, strobe LoadReq, pulse Start to both
// cores, collect both results under a watchdog, compare and accumulate.
//   Clock, nReset            : core clock, asynchronous active-low reset
//   Go                       : campaign enable level (low aborts / acknowledges)
//   NumRuns                  : runs per campaign, latched on leaving IDLE
//   DataReady                : input shift register holds a new vector
//   LoadReq, Start           : registered one-cycle strobes
//   Ready/Valid/Errors 1,2   : per-core result handshakes
//   Busy, Done, Timeout      : campaign status (Timeout sticky per campaign)
//   RunIdx, MismatchCnt      : runs completed, runs whose results differ
//   ErrSum1, ErrSum2         : saturating sums of valid Errors per core
module fptd_run_seq
  import fptd_seq_pkg::*;
#(
  parameter int EW   = EW_DEF,
  parameter int RW   = RW_DEF,
  parameter int SW   = SW_DEF,
  parameter int TMAX = TMAX_DEF,
  parameter int TW   = TW_DEF
) (
  input  logic          Clock,
  input  logic          nReset,
  input  logic          Go,
  input  logic [RW-1:0] NumRuns,
  input  logic          DataReady,
  output logic          LoadReq,
  output logic          Start,
  input  logic          Ready1,
  input  logic          Valid1,
  input  logic [EW-1:0] Errors1,
  input  logic          Ready2,
  input  logic          Valid2,
  input  logic [EW-1:0] Errors2,
  output logic          Busy,
  output logic          Done,
  output logic          Timeout,
  output logic [RW-1:0] RunIdx,
  output logic [RW-1:0] MismatchCnt,
  output logic [SW-1:0] ErrSum1,
  output logic [SW-1:0] ErrSum2
);

  localparam logic [31:0] MM_MAX  = 32'((64'd1 << RW) - 64'd1);
  localparam logic [31:0] SUM_MAX = 32'((64'd1 << SW) - 64'd1);

  seq_state_t    r_state, w_next;
  logic          r_load_req, r_start, r_timeout;
  logic          r_seen1, r_seen2;
  core_res_t     r_res1, r_res2;
  logic [RW-1:0] r_num_runs, r_run_idx, r_mm;
  logic [SW-1:0] r_sum1, r_sum2;

  logic          w_busy, w_done, w_wdog_en, w_wdog_clr, w_expire;
  logic          w_take1, w_take2, w_both, w_mismatch;
  logic [RW-1:0] w_run_idx_inc;

  fptd_seq_wdog #(.TW(TW), .TMAX(TMAX)) u_wdog (
    .i_clk   (Clock),
    .i_rst_n (nReset),
    .i_clr   (w_wdog_clr),
    .i_en    (w_wdog_en),
    .o_expire(w_expire)
  );

  // Only the first Ready per core per run is taken.
  assign w_take1       = (r_state == S_WAIT_RDY) && Ready1 && !r_seen1;
  assign w_take2       = (r_state == S_WAIT_RDY) && Ready2 && !r_seen2;
  assign w_both        = (r_seen1 || w_take1) && (r_seen2 || w_take2);
  assign w_run_idx_inc = r_run_idx + RW'(1);
  assign w_mismatch    = (r_res1.valid != r_res2.valid) ||
                         (r_res1.valid && r_res2.valid && (r_res1.errors != r_res2.errors));

  // State register
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (Go) w_next = (NumRuns == '0) ? S_DONE : S_WAIT_DATA;
      S_WAIT_DATA: if (DataReady) w_next = S_LOAD;
      S_LOAD:      w_next = S_START;
      S_START:     w_next = S_WAIT_RDY;
      S_WAIT_RDY: begin
        // A result landing on the expiry cycle still counts.
        if (w_both)        w_next = S_COMPARE;
        else if (w_expire) w_next = S_DONE;
      end
      S_COMPARE:   w_next = S_NEXT;
      S_NEXT:      w_next = (w_run_idx_inc == r_num_runs) ? S_DONE : S_WAIT_DATA;
      S_DONE:      if (!Go) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
    if (w_busy && !Go) w_next = S_IDLE;
  end

  // State-decoded outputs
  always_comb begin
    w_busy     = 1'b1;
    w_done     = 1'b0;
    w_wdog_en  = (r_state == S_WAIT_RDY);
    w_wdog_clr = (r_state == S_START);
    case (r_state)
      S_IDLE:  w_busy = 1'b0;
      S_DONE: begin
        w_busy = 1'b0;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: strobes, capture registers, counters and sums.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_load_req <= 1'b0;
      r_start    <= 1'b0;
      r_timeout  <= 1'b0;
      r_seen1    <= 1'b0;
      r_seen2    <= 1'b0;
      r_res1     <= '0;
      r_res2     <= '0;
      r_num_runs <= '0;
      r_run_idx  <= '0;
      r_mm       <= '0;
      r_sum1     <= '0;
      r_sum2     <= '0;
    end else begin
      // Strobes are flopped from the next state so they coincide exactly
      // with LOAD / START and never follow an input combinationally.
      r_load_req <= (w_next == S_LOAD);
      r_start    <= (w_next == S_START);

      if ((r_state == S_IDLE) && (w_next != S_IDLE)) begin
        r_num_runs <= NumRuns;
        r_run_idx  <= '0;
        r_mm       <= '0;
        r_sum1     <= '0;
        r_sum2     <= '0;
        r_timeout  <= 1'b0;
      end

      if (r_state == S_START) begin
        r_seen1 <= 1'b0;
        r_seen2 <= 1'b0;
      end
      if (w_take1) begin
        r_seen1       <= 1'b1;
        r_res1.valid  <= Valid1;
        r_res1.errors <= EW_MAX'(Errors1);
      end
      if (w_take2) begin
        r_seen2       <= 1'b1;
        r_res2.valid  <= Valid2;
        r_res2.errors <= EW_MAX'(Errors2);
      end

      if ((r_state == S_WAIT_RDY) && (w_next == S_DONE)) r_timeout <= 1'b1;

      if (r_state == S_COMPARE) begin
        if (w_mismatch) r_mm <= RW'(sat_add(32'(r_mm), 32'd1, MM_MAX));
        if (r_res1.valid) r_sum1 <= SW'(sat_add(32'(r_sum1), 32'(r_res1.errors), SUM_MAX));
        if (r_res2.valid) r_sum2 <= SW'(sat_add(32'(r_sum2), 32'(r_res2.errors), SUM_MAX));
      end

      if (r_state == S_NEXT) r_run_idx <= w_run_idx_inc;
    end
  end

  assign LoadReq     = r_load_req;
  assign Start       = r_start;
  assign Busy        = w_busy;
  assign Done        = w_done;
  assign Timeout     = r_timeout;
  assign RunIdx      = r_run_idx;
  assign MismatchCnt = r_mm;
  assign ErrSum1     = r_sum1;
  assign ErrSum2     = r_sum2;

endmodule

// File: tb/tb_fptd_run_seq.sv
// Self-checking bench for fptd_run_seq. A second instance with 4-bit error
// sums shares every input so saturation is observed alongside normal runs.
module tb_fptd_run_seq;

  localparam int EW = 7, RW = 8, SW = 16, TMAX = 255, SW_SAT = 4;

  logic          Clock, nReset, Go, DataReady;
  logic [RW-1:0] NumRuns;
  logic          Ready1, Valid1, Ready2, Valid2;
  logic [EW-1:0] Errors1, Errors2;
  logic          LoadReq, Start, Busy, Done, Timeout;
  logic [RW-1:0] RunIdx, MismatchCnt;
  logic [SW-1:0] ErrSum1, ErrSum2;

  logic              s_load, s_start, s_busy, s_done, s_timeout;
  logic [RW-1:0]     s_run_idx, s_mm;
  logic [SW_SAT-1:0] s_sum1, s_sum2;

  int checks, errors;
  int n_load, n_start, n_sload, n_sstart;
  int exp_run, exp_mm, exp_s1, exp_s2;

  fptd_run_seq #(.EW(EW), .RW(RW), .SW(SW), .TMAX(TMAX)) u_dut (
    .Clock(Clock), .nReset(nReset), .Go(Go), .NumRuns(NumRuns), .DataReady(DataReady),
    .LoadReq(LoadReq), .Start(Start),
    .Ready1(Ready1), .Valid1(Valid1), .Errors1(Errors1),
    .Ready2(Ready2), .Valid2(Valid2), .Errors2(Errors2),
    .Busy(Busy), .Done(Done), .Timeout(Timeout), .RunIdx(RunIdx),
    .MismatchCnt(MismatchCnt), .ErrSum1(ErrSum1), .ErrSum2(ErrSum2)
  );

  fptd_run_seq #(.EW(EW), .RW(RW), .SW(SW_SAT), .TMAX(TMAX)) u_dut_sat (
    .Clock(Clock), .nReset(nReset), .Go(Go), .NumRuns(NumRuns), .DataReady(DataReady),
    .LoadReq(s_load), .Start(s_start),
    .Ready1(Ready1), .Valid1(Valid1), .Errors1(Errors1),
    .Ready2(Ready2), .Valid2(Valid2), .Errors2(Errors2),
    .Busy(s_busy), .Done(s_done), .Timeout(s_timeout), .RunIdx(s_run_idx),
    .MismatchCnt(s_mm), .ErrSum1(s_sum1), .ErrSum2(s_sum2)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and count strobe cycles seen there.
  task automatic tick();
    @(negedge Clock);
    if (LoadReq)  n_load++;
    if (Start)    n_start++;
    if (s_load)   n_sload++;
    if (s_start)  n_sstart++;
  endtask

  function automatic int sat(input int v, input int max_v);
    return (v > max_v) ? max_v : v;
  endfunction

  // Reference model: one completed run, straight from the comparison rules.
  task automatic model_run(input logic v1, input int e1, input logic v2, input int e2);
    exp_run++;
    if ((v1 != v2) || (v1 && v2 && (e1 != e2))) exp_mm++;
    if (v1) exp_s1 += e1;
    if (v2) exp_s2 += e2;
  endtask

  task automatic start_campaign(input int n);
    NumRuns = RW'(n);
    Go      = 1'b1;
    exp_run = 0; exp_mm = 0; exp_s1 = 0; exp_s2 = 0;
  endtask

  // Wait (bounded) for Start; optionally toggle DataReady and inject stray
  // Ready pulses, which must be ignored outside WAIT_RDY.
  task automatic wait_start(input bit rnd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      if (Start) begin
        ok = 1'b1;
        Ready1 = 1'b0;
        Ready2 = 1'b0;
      end else if (rnd) begin
        DataReady = ($urandom_range(0, 1) == 1);
        Ready1    = ($urandom_range(0, 3) == 0);
        Ready2    = ($urandom_range(0, 3) == 0);
        Valid1    = ($urandom_range(0, 1) == 1);
        Valid2    = ($urandom_range(0, 1) == 1);
        Errors1   = EW'($urandom_range(0, 127));
        Errors2   = EW'($urandom_range(0, 127));
      end
    end
    if (rnd) DataReady = 1'b1;
  endtask

  // Called at the falling edge where Start is high. Core n answers d_n cycles
  // into WAIT_RDY; a nonzero dup adds a later, differing Ready1 pulse.
  task automatic respond(input int d1, input int d2, input int dup,
                         input logic v1, input logic [EW-1:0] e1,
                         input logic v2, input logic [EW-1:0] e2);
    int dmax;
    dmax = (d1 > d2) ? d1 : d2;
    if (dup > dmax) dmax = dup;
    for (int c = 1; c <= dmax; c++) begin
      tick();
      Ready1  = (c == d1) || (c == dup);
      Valid1  = (c == d1) ? v1 : ~v1;
      Errors1 = (c == d1) ? e1 : ~e1;
      Ready2  = (c == d2);
      Valid2  = (c == d2) ? v2 : ~v2;
      Errors2 = (c == d2) ? e2 : ~e2;
    end
    tick();
    Ready1 = 1'b0;
    Ready2 = 1'b0;
    model_run(v1, int'(e1), v2, int'(e2));
  endtask

  task automatic do_run(input bit rnd, input int d1, input int d2, input int dup,
                        input logic v1, input logic [EW-1:0] e1,
                        input logic v2, input logic [EW-1:0] e2);
    bit ok;
    wait_start(rnd, ok);
    check("start_seen", 32'(ok), 32'd1);
    if (ok) respond(d1, d2, dup, v1, e1, v2, e2);
  endtask

  task automatic random_run();
    int d1, d2, dup;
    logic v1, v2;
    logic [EW-1:0] e1, e2;
    d1  = $urandom_range(1, 6);
    d2  = $urandom_range(1, 6);
    dup = ($urandom_range(0, 1) == 1) ? d1 + $urandom_range(1, 2) : 0;
    v1  = ($urandom_range(0, 3) != 0);
    v2  = ($urandom_range(0, 3) != 0);
    e1  = EW'($urandom_range(0, 127));
    e2  = ($urandom_range(0, 1) == 1) ? e1 : EW'($urandom_range(0, 127));
    do_run(1'b1, d1, d2, dup, v1, e1, v2, e2);
  endtask

  // Wait (bounded) for Done, compare everything against the model, then
  // drop Go and confirm the acknowledge.
  task automatic finish_campaign(input string tag, input bit exp_to);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (Done) ok = 1'b1;
      else tick();
    end
    check({tag, "_done"},    32'(ok), 32'd1);
    check({tag, "_busy"},    32'(Busy), 32'd0);
    check({tag, "_timeout"}, 32'(Timeout), 32'(exp_to));
    check({tag, "_run_idx"}, 32'(RunIdx), 32'(exp_run));
    check({tag, "_mm"},      32'(MismatchCnt), 32'(sat(exp_mm, 255)));
    check({tag, "_sum1"},    32'(ErrSum1), 32'(sat(exp_s1, 65535)));
    check({tag, "_sum2"},    32'(ErrSum2), 32'(sat(exp_s2, 65535)));
    check({tag, "_sat_done"},    32'(s_done), 32'd1);
    check({tag, "_sat_timeout"}, 32'(s_timeout), 32'(exp_to));
    check({tag, "_sat_run_idx"}, 32'(s_run_idx), 32'(exp_run));
    check({tag, "_sat_mm"},      32'(s_mm), 32'(sat(exp_mm, 255)));
    check({tag, "_sat_sum1"},    32'(s_sum1), 32'(sat(exp_s1, 15)));
    check({tag, "_sat_sum2"},    32'(s_sum2), 32'(sat(exp_s2, 15)));
    Go = 1'b0;
    tick();
    check({tag, "_ack"}, 32'(Done), 32'd0);
  endtask

  initial begin
    bit ok;
    int ns;
    checks = 0; errors = 0;
    n_load = 0; n_start = 0; n_sload = 0; n_sstart = 0;
    exp_run = 0; exp_mm = 0; exp_s1 = 0; exp_s2 = 0;
    nReset = 1'b0; Go = 1'b0; NumRuns = '0; DataReady = 1'b0;
    Ready1 = 1'b0; Valid1 = 1'b0; Errors1 = '0;
    Ready2 = 1'b0; Valid2 = 1'b0; Errors2 = '0;

    // Reset state
    tick(); tick();
    check("rst_busy",  32'(Busy), 32'd0);
    check("rst_done",  32'(Done), 32'd0);
    check("rst_load",  32'(LoadReq), 32'd0);
    check("rst_start", 32'(Start), 32'd0);
    check("rst_to",    32'(Timeout), 32'd0);
    check("rst_run",   32'(RunIdx), 32'd0);
    check("rst_mm",    32'(MismatchCnt), 32'd0);
    check("rst_sum1",  32'(ErrSum1), 32'd0);
    check("rst_sum2",  32'(ErrSum2), 32'd0);
    nReset = 1'b1;
    tick();

    // Basic: 3 runs, E1=E2=5, both Ready together; latency on the first run
    start_campaign(3);
    tick();
    check("basic_busy",   32'(Busy), 32'd1);
    check("basic_noload", 32'(LoadReq), 32'd0);
    tick();
    check("basic_hold_wait", 32'(LoadReq), 32'd0);
    DataReady = 1'b1;
    tick();
    check("lat_load",    32'(LoadReq), 32'd1);
    check("lat_nostart", 32'(Start), 32'd0);
    tick();
    check("lat_start",   32'(Start), 32'd1);
    check("lat_noload",  32'(LoadReq), 32'd0);
    respond(1, 1, 0, 1'b1, 7'd5, 1'b1, 7'd5);
    do_run(1'b0, 1, 1, 0, 1'b1, 7'd5, 1'b1, 7'd5);
    do_run(1'b0, 1, 1, 0, 1'b1, 7'd5, 1'b1, 7'd5);
    finish_campaign("basic", 1'b0);
    check("basic_run3",   32'(RunIdx), 32'd3);
    check("basic_sum15",  32'(ErrSum1), 32'd15);
    check("basic_loads",  32'(n_load), 32'd3);
    check("basic_starts", 32'(n_start), 32'd3);
    check("basic_sat_starts", 32'(n_sstart), 32'd3);
    check("basic_sat_loads",  32'(n_sload), 32'd3);

    // Zero runs: Done on the cycle after Go, counts cleared, no Start
    ns = n_start;
    start_campaign(0);
    tick();
    check("zero_done",  32'(Done), 32'd1);
    check("zero_busy",  32'(Busy), 32'd0);
    check("zero_run",   32'(RunIdx), 32'd0);
    check("zero_sum1",  32'(ErrSum1), 32'd0);
    check("zero_start", 32'(n_start), 32'(ns));
    finish_campaign("zero", 1'b0);

    // Skewed / mismatch, plus an ignored duplicate Ready1
    start_campaign(2);
    do_run(1'b0, 1, 5, 2, 1'b1, 7'd3, 1'b1, 7'd4);
    do_run(1'b0, 2, 3, 0, 1'b1, 7'd2, 1'b0, 7'd6);
    finish_campaign("skew", 1'b0);
    check("skew_mm2",   32'(MismatchCnt), 32'd2);
    check("skew_sum1",  32'(ErrSum1), 32'd5);
    check("skew_sum2",  32'(ErrSum2), 32'd4);

    // Saturation of the 4-bit instance: 3 x 7 = 21 -> 15
    start_campaign(3);
    for (int r = 0; r < 3; r++) do_run(1'b0, 1, 2, 0, 1'b1, 7'd7, 1'b1, 7'd7);
    finish_campaign("satur", 1'b0);
    check("satur_sum4",  32'(s_sum1), 32'd15);
    check("satur_sum16", 32'(ErrSum1), 32'd21);

    // Timeout: run 2 gets only Ready1
    start_campaign(4);
    do_run(1'b0, 2, 3, 0, 1'b1, 7'd10, 1'b1, 7'd10);
    wait_start(1'b0, ok);
    check("to_start_seen", 32'(ok), 32'd1);
    for (int k = 1; k <= TMAX; k++) begin
      tick();
      Ready1  = (k == 1);
      Valid1  = 1'b1;
      Errors1 = 7'd9;
    end
    check("to_not_yet", 32'(Timeout), 32'd0);
    check("to_busy",    32'(Busy), 32'd1);
    tick();
    check("to_edge",    32'(Timeout), 32'd1);
    finish_campaign("timeout", 1'b1);
    check("to_run1",    32'(RunIdx), 32'd1);
    check("to_sticky",  32'(Timeout), 32'd1);

    // Asynchronous reset while holding results in IDLE
    #2 nReset = 1'b0;
    #1;
    check("arst_to",   32'(Timeout), 32'd0);
    check("arst_run",  32'(RunIdx), 32'd0);
    check("arst_sum1", 32'(ErrSum1), 32'd0);
    tick();
    nReset = 1'b1;
    tick();

    // Reset asserted mid-LOAD
    start_campaign(2);
    tick();
    tick();
    check("mid_load", 32'(LoadReq), 32'd1);
    #2 nReset = 1'b0;
    #1;
    check("mid_rst_load",  32'(LoadReq), 32'd0);
    check("mid_rst_busy",  32'(Busy), 32'd0);
    check("mid_rst_start", 32'(Start), 32'd0);
    Go = 1'b0;
    tick();
    nReset = 1'b1;
    tick();

    // Abort during WAIT_RDY, then re-raise Go
    start_campaign(5);
    do_run(1'b0, 1, 1, 0, 1'b1, 7'd20, 1'b1, 7'd21);
    wait_start(1'b0, ok);
    check("ab_start_seen", 32'(ok), 32'd1);
    tick(); tick();
    Go = 1'b0;
    tick();
    check("ab_busy", 32'(Busy), 32'd0);
    check("ab_done", 32'(Done), 32'd0);
    ns = n_start;
    repeat (6) tick();
    check("ab_no_start", 32'(n_start), 32'(ns));
    check("ab_hold_run", 32'(RunIdx), 32'(exp_run));
    check("ab_hold_mm",  32'(MismatchCnt), 32'(exp_mm));
    check("ab_hold_s1",  32'(ErrSum1), 32'(exp_s1));
    start_campaign(1);
    tick();
    check("ab_clr_run", 32'(RunIdx), 32'd0);
    check("ab_clr_mm",  32'(MismatchCnt), 32'd0);
    check("ab_clr_s1",  32'(ErrSum1), 32'd0);
    do_run(1'b0, 3, 1, 0, 1'b0, 7'd1, 1'b1, 7'd8);
    finish_campaign("rego", 1'b0);

    // Randomized campaigns against the model
    for (int k = 0; k < 8; k++) begin
      start_campaign($urandom_range(1, 5));
      for (int r = 0; r < int'(NumRuns); r++) random_run();
      finish_campaign("rand", 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
